// File: rtl/ddr3_pkg.sv
// Shared DDR3 read-path definitions: MIG command codes, scheduler FSM states
// and output FIFO geometry.
package ddr3_pkg;

   localparam logic [2:0] MIG_CMD_READ  = 3'b001;
   localparam logic [2:0] MIG_CMD_WRITE = 3'b000;

   localparam int unsigned OUTFIFO_DEPTH = 64;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } rd_state_t;

endpackage

// File: rtl/ddr3_credit_cnt.sv
// Outstanding-read counter and FIFO credit check for the DDR3 read scheduler.
// Credit counts free FIFO slots not yet claimed by reads in flight.
module ddr3_credit_cnt #(
   parameter int unsigned LEN_W      = 16,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned SLACK      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       accept,
   input  logic       rd_valid,
   input  logic       fifo_wr_en,
   input  logic [6:0] fifo_data_count,
   output logic [6:0] outstanding,
   output logic       can_issue,
   output logic       can_issue_next
);

   localparam int unsigned CW = LEN_W + 2;

   logic signed [CW-1:0] credit;

   // A stray beat with nothing outstanding must not wrap the counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
      end else if (accept && !rd_valid) begin
         outstanding <= outstanding + 7'd1;
      end else if (!accept && rd_valid && outstanding != '0) begin
         outstanding <= outstanding - 7'd1;
      end
   end

   always_comb begin
      credit = $signed(CW'(FIFO_DEPTH)) - $signed(CW'(fifo_data_count))
             - $signed(CW'(outstanding)) - $signed(CW'(fifo_wr_en))
             - $signed(CW'(SLACK));
      can_issue      = credit > $signed(CW'(0));
      // Back-to-back issue needs room for the command being accepted now.
      can_issue_next = credit > $signed(CW'(1));
   end

endmodule

// File: rtl/ddr3_rd_scheduler.sv
// Credit-gated MIG read command issuer; forwards returned 512-bit beats to the
// DDR3 output FIFO through a one-cycle register.
module ddr3_rd_scheduler
   import ddr3_pkg::*;
#(
   parameter int unsigned ADDR_W     = 28,
   parameter int unsigned LEN_W      = 16,
   parameter int unsigned BURST_INC  = 8,
   parameter int unsigned FIFO_DEPTH = OUTFIFO_DEPTH,
   parameter int unsigned SLACK      = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_bursts,
   output logic              busy,
   output logic              done,
   output logic              err_ovf,
   output logic              app_en,
   output logic [2:0]        app_cmd,
   output logic [ADDR_W-1:0] app_addr,
   input  logic              app_rdy,
   input  logic [511:0]      app_rd_data,
   input  logic              app_rd_data_valid,
   output logic [511:0]      fifo_din,
   output logic              fifo_wr_en,
   input  logic [6:0]        fifo_data_count
);

   rd_state_t         state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining;
   logic [6:0]        outstanding;
   logic              accept, can_issue, can_issue_next, app_en_nxt;

   assign accept = app_en && app_rdy;

   ddr3_credit_cnt #(
      .LEN_W      (LEN_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .SLACK      (SLACK)
   ) u_credit (
      .clk             (clk),
      .rst             (rst_n),
      .accept          (accept),
      .rd_valid        (app_rd_data_valid),
      .fifo_wr_en      (fifo_wr_en),
      .fifo_data_count (fifo_data_count),
      .outstanding     (outstanding),
      .can_issue       (can_issue),
      .can_issue_next  (can_issue_next)
   );

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (num_bursts == '0) ? DONE : ISSUE;
         ISSUE:   if (accept && remaining == LEN_W'(1)) state_nxt = DRAIN;
         DRAIN:   if (outstanding == '0 && !fifo_wr_en) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == ISSUE) || (state == DRAIN);
      done     = (state == DONE);
      app_cmd  = MIG_CMD_READ;
      app_addr = addr;
   end

   // Once raised, app_en holds until accepted regardless of credit.
   always_comb begin
      if (accept)
         app_en_nxt = (remaining > LEN_W'(1)) && can_issue_next;
      else
         app_en_nxt = app_en || ((state == ISSUE) && (remaining != '0) && can_issue);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         addr      <= '0;
         remaining <= '0;
         app_en    <= 1'b0;
      end else begin
         app_en <= app_en_nxt;
         if (state == IDLE && start) begin
            addr      <= base_addr;
            remaining <= num_bursts;
         end else if (accept) begin
            addr      <= addr + ADDR_W'(BURST_INC);
            remaining <= remaining - LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         fifo_wr_en <= 1'b0;
         fifo_din   <= '0;
         err_ovf    <= 1'b0;
      end else begin
         fifo_wr_en <= app_rd_data_valid;
         fifo_din   <= app_rd_data;
         if (app_rd_data_valid && outstanding == '0 && !accept) err_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ddr3_rd_scheduler.sv
// Directed bench for ddr3_rd_scheduler with a simple MIG read responder model.
module tb_ddr3_rd_scheduler;

   localparam int unsigned ADDR_W = 28;
   localparam int unsigned LEN_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n, start, app_rdy;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  num_bursts;
   logic              busy, done, err_ovf, app_en, fifo_wr_en, app_rd_data_valid;
   logic [2:0]        app_cmd;
   logic [ADDR_W-1:0] app_addr;
   logic [511:0]      app_rd_data, fifo_din;
   logic [6:0]        fifo_data_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Responder / monitor state: written only by the responder process.
   int                cyc = 0, out_model = 0, max_out = 0, wr_cnt = 0, done_cnt = 0, inj_ack = 0;
   bit                busy_at_done = 1'b0;
   logic [511:0]      last_din = '0;
   logic [ADDR_W-1:0] acc_q[$];
   int                due_q[$];
   logic [511:0]      dat_q[$];

   // Controls: written only by the main process.
   int                lat = 5, inj_req = 0;
   bit                hold = 1'b0;
   logic [511:0]      inj_data = '0;
   int                acc_base = 0, wr_base = 0, done_base = 0;

   always #5 clk = ~clk;

   ddr3_rd_scheduler #(
      .ADDR_W     (28),
      .LEN_W      (16),
      .BURST_INC  (8),
      .FIFO_DEPTH (64),
      .SLACK      (2)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .base_addr         (base_addr),
      .num_bursts        (num_bursts),
      .busy              (busy),
      .done              (done),
      .err_ovf           (err_ovf),
      .app_en            (app_en),
      .app_cmd           (app_cmd),
      .app_addr          (app_addr),
      .app_rdy           (app_rdy),
      .app_rd_data       (app_rd_data),
      .app_rd_data_valid (app_rd_data_valid),
      .fifo_din          (fifo_din),
      .fifo_wr_en        (fifo_wr_en),
      .fifo_data_count   (fifo_data_count)
   );

   function automatic logic [511:0] pat(input logic [ADDR_W-1:0] a);
      return {16{4'hA, a}};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic mark();
      acc_base  = acc_q.size();
      wr_base   = wr_cnt;
      done_base = done_cnt;
   endtask

   task automatic launch(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
      base_addr  = b;
      num_bursts = n;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (done_cnt == done_base && k < budget) begin
         step();
         k++;
      end
      check(tag, 64'(done_cnt - done_base), 64'd1);
      step(3);
   endtask

   // MIG model: acts at negedges, away from the DUT's active edge.
   initial begin
      app_rd_data_valid = 1'b0;
      app_rd_data       = '0;
      forever begin
         @(negedge clk);
         cyc++;
         app_rd_data_valid = 1'b0;
         if (rst_n) begin
            due_q.delete();
            dat_q.delete();
            out_model = 0;
         end else begin
            if (inj_req != inj_ack) begin
               app_rd_data_valid = 1'b1;
               app_rd_data       = inj_data;
               inj_ack++;
            end else if (!hold && due_q.size() > 0 && due_q[0] <= cyc) begin
               app_rd_data_valid = 1'b1;
               app_rd_data       = dat_q.pop_front();
               void'(due_q.pop_front());
               out_model--;
            end
            if (app_en && app_rdy) begin
               acc_q.push_back(app_addr);
               due_q.push_back(cyc + lat);
               dat_q.push_back(pat(app_addr));
               out_model++;
               if (out_model > max_out) max_out = out_model;
            end
            if (fifo_wr_en) begin
               wr_cnt++;
               last_din = fifo_din;
            end
            if (done) begin
               done_cnt++;
               busy_at_done = busy;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] e;
      bit           any_en;
      int           k;

      rst_n = 1'b1; start = 1'b0; base_addr = '0; num_bursts = '0;
      app_rdy = 1'b1; fifo_data_count = '0;
      step(3);
      check("rst_busy",   64'(busy),       64'd0);
      check("rst_done",   64'(done),       64'd0);
      check("rst_err",    64'(err_ovf),    64'd0);
      check("rst_app_en", 64'(app_en),     64'd0);
      check("rst_cmd",    64'(app_cmd),    64'd1);
      check("rst_addr",   64'(app_addr),   64'd0);
      check("rst_wr_en",  64'(fifo_wr_en), 64'd0);
      check("rst_din",    64'(fifo_din != '0), 64'd0);
      rst_n = 1'b0;
      step(2);

      // 1: four bursts from 0x100, 5-cycle read latency
      mark(); lat = 5;
      launch(28'h100, 16'd4);
      check("t1_busy", 64'(busy), 64'd1);
      wait_done("t1_done", 100);
      check("t1_done_once", 64'(done_cnt - done_base), 64'd1);
      check("t1_busy_fall", 64'(busy_at_done), 64'd0);
      check("t1_nacc", 64'(acc_q.size() - acc_base), 64'd4);
      for (int i = 0; i < 4; i++)
         check("t1_addr", 64'(acc_q[acc_base + i]), 64'(28'h100 + 8 * i));
      check("t1_beats", 64'(wr_cnt - wr_base), 64'd4);
      e = pat(28'h118);
      check("t1_last_din", last_din[63:0], e[63:0]);
      check("t1_err", 64'(err_ovf), 64'd0);

      // 2: credit gating by FIFO fill level
      mark(); hold = 1'b1; fifo_data_count = 7'd62;
      launch(28'h1000, 16'd30);
      any_en = 1'b0;
      repeat (10) begin
         step();
         any_en |= app_en;
      end
      check("t2_blocked", 64'(any_en), 64'd0);
      fifo_data_count = 7'd40;
      step(40);
      check("t2_nacc_capped", 64'(acc_q.size() - acc_base), 64'd22);
      check("t2_stalled", 64'(app_en), 64'd0);
      hold = 1'b0; lat = 2;
      wait_done("t2_done", 400);
      check("t2_nacc_all", 64'(acc_q.size() - acc_base), 64'd30);
      check("t2_beats", 64'(wr_cnt - wr_base), 64'd30);
      check("t2_max_out_le22", 64'(max_out <= 22), 64'd1);
      fifo_data_count = '0;

      // 3: app_rdy held low while a command is pending
      mark(); lat = 3; app_rdy = 1'b0;
      launch(28'h200, 16'd1);
      k = 0;
      while (!app_en && k < 10) begin
         step();
         k++;
      end
      check("t3_en_up", 64'(app_en), 64'd1);
      for (int i = 0; i < 3; i++) begin
         check("t3_hold_en", 64'(app_en), 64'd1);
         check("t3_hold_addr", 64'(app_addr), 64'h200);
         step();
      end
      check("t3_no_acc", 64'(acc_q.size() - acc_base), 64'd0);
      app_rdy = 1'b1;
      step();
      check("t3_acc", 64'(acc_q.size() - acc_base), 64'd1);
      check("t3_en_drop", 64'(app_en), 64'd0);
      wait_done("t3_done", 50);
      check("t3_addr", 64'(acc_q[acc_base]), 64'h200);

      // 4: zero-length job, then address wrap
      mark();
      launch(28'h0, 16'd0);
      check("t4_done", 64'(done), 64'd1);
      check("t4_no_en", 64'(app_en), 64'd0);
      check("t4_busy", 64'(busy), 64'd0);
      step();
      check("t4_done_pulse", 64'(done), 64'd0);
      step(2);
      mark(); lat = 5;
      launch(28'hFFFFFF8, 16'd2);
      wait_done("t4_wrap_done", 60);
      check("t4_nacc", 64'(acc_q.size() - acc_base), 64'd2);
      check("t4_addr0", 64'(acc_q[acc_base]), 64'hFFFFFF8);
      check("t4_addr1_wrap", 64'(acc_q[acc_base + 1]), 64'h0);

      // 5: accept and return in the same cycle, then a stray beat in IDLE
      mark(); lat = 1;
      launch(28'h300, 16'd4);
      wait_done("t5_done", 60);
      check("t5_done_once", 64'(done_cnt - done_base), 64'd1);
      check("t5_beats", 64'(wr_cnt - wr_base), 64'd4);
      check("t5_err_clean", 64'(err_ovf), 64'd0);
      inj_data = pat(28'h7777);
      inj_req++;
      step();
      check("t5_stray_wr", 64'(fifo_wr_en), 64'd1);
      e = pat(28'h7777);
      check("t5_stray_din", fifo_din[63:0], e[63:0]);
      check("t5_stray_err", 64'(err_ovf), 64'd1);
      step();
      check("t5_err_sticky", 64'(err_ovf), 64'd1);

      // 6: reset in the middle of ISSUE, then a clean job
      mark(); lat = 5;
      launch(28'h500, 16'd10);
      step(4);
      check("t6_midjob_busy", 64'(busy), 64'd1);
      rst_n = 1'b1;
      step();
      check("t6_rst_en", 64'(app_en), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_err", 64'(err_ovf), 64'd0);
      check("t6_rst_addr", 64'(app_addr), 64'd0);
      rst_n = 1'b0;
      step(2);
      mark();
      launch(28'h400, 16'd3);
      wait_done("t6_done", 60);
      check("t6_nacc", 64'(acc_q.size() - acc_base), 64'd3);
      for (int i = 0; i < 3; i++)
         check("t6_addr", 64'(acc_q[acc_base + i]), 64'(28'h400 + 8 * i));
      check("t6_beats", 64'(wr_cnt - wr_base), 64'd3);
      check("t6_err", 64'(err_ovf), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
